timer_scheduler: RTL
====================

Name: timer_scheduler

Overview:
- Avalon-MM master that time-shares the single interval timer peripheral (16-bit slave, register map below) among NUM_REQ hardware requesters, e.g. envelope tick, MIDI running-status timeout and USB poll.
- Round-robin arbitration; per grant the block programs a 32-bit period, starts a one-shot timeout, waits for irq, clears status and pulses the winner's done.
- Includes a watchdog and requester abort.
- Timer register map it drives: 0 = status (write clears TO), 1 = control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2..5 = period halfwords 0..3.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WDOG_CYCLES, 32'hFFFF_FFFF, max WAIT cycles before forced stop; must be > largest period + 8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  level request; held high until done or err, low means abort
- req_period  in  32*NUM_REQ  period for requester i in bits [32i+31:32i]; sampled at grant
- done  out  NUM_REQ  one-cycle pulse on the granted bit on normal timeout
- err  out  1  one-cycle pulse on watchdog expiry
- grant_id  out  3  index of current/last grant
- busy  out  1  high in every state except IDLE
- tmr_address  out  4  timer slave address
- tmr_chipselect  out  1  high only in write states
- tmr_write_n  out  1  low only in write states
- tmr_writedata  out  16  write data
- tmr_irq  in  1  timer interrupt (level)

Behaviour:
- Reset values: done=0, err=0, grant_id=0, busy=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, rr pointer=0, state=IDLE. All outputs are registered.
- Reset mid-operation returns to IDLE immediately. The timer is not touched; the next grant's period writes force-reload it.
- IDLE: if any req bit is set, pick the first set bit at or after the rr pointer (wrapping). Latch grant_id and the period into a 32-bit register. Go to W_P0.
- W_P0/W_P1/W_P2/W_P3: one write per cycle.
  - Addr 2 carries period[15:0].
  - Addr 3 carries period[31:16].
  - Addr 4 and addr 5 carry 0.
- SETTLE: one idle bus cycle so the timer's force_reload stop completes before START.
- W_CTRL: write addr 1, data 16'h0005 (START|ITO, one-shot).
- WAIT: no bus activity; the watchdog counter counts up from 0.
  - tmr_irq=1: go to W_CLR, set ok flag.
  - req[grant_id]=0: go to W_STOP; abort has priority over a same-cycle irq.
  - Watchdog reaches WDOG_CYCLES-1: go to W_STOP, set wd flag.
- W_STOP: write addr 1, data 16'h0008. Go to W_CLR.
- W_CLR: write addr 0, data 0 (clears TO and drops irq). Go to FIN.
- FIN: pulse exactly one of the following, then return to IDLE:
  - done[grant_id] if ok.
  - err if wd.
  - Nothing if aborted.
- rr pointer = grant_id+1 mod NUM_REQ, updated in FIN in all three cases.
- Period 0 is written verbatim; the timer expires almost immediately and done follows normally.
- req changes on non-granted bits are ignored until IDLE. req_period is not re-sampled during a grant.
- Minimum turnaround IDLE to done: 9 cycles plus the timer count (≈ period+2 cycles after W_CTRL).

Test Plan:
- Single request: req=4'b0001, period=100 -> bus writes (2,100),(3,0),(4,0),(5,0), idle cycle, (1,0x0005); irq ≈102 cycles later; write (0,0); done[0] pulses once; busy low next cycle.
- Round robin: req=4'b1111 held, periods 10/20/30/40 -> done order 0,1,2,3,0; grant_id matches each; no starvation.
- Abort: req[2] alone, period=1000, drop req[2] 50 cycles into WAIT -> writes (1,0x0008) then (0,0); no done and no err; returns to IDLE.
- Watchdog: WDOG_CYCLES=64, tmr_irq tied 0, period=10 -> err pulses after 64 WAIT cycles, stop and clear writes issued, done stays 0.
- Period upper half: period=32'h0001_869F -> writes (2,0x869F),(3,0x0001); done ≈100002 cycles after W_CTRL.
- Async reset asserted in WAIT -> all outputs at reset values without a clock edge; after release, a fresh req=4'b0010 is granted with rr=0 (grant_id=1).

Source files
------------

// File: rtl/timer_scheduler.sv
// Avalon-MM master that time-shares one interval timer among NUM_REQ requesters.
// Round-robin grant, program period, one-shot start, wait for irq/abort/watchdog, clear, report.
module timer_scheduler #(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] WDOG_CYCLES = 32'hFFFF_FFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_period,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic [3:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);

  typedef enum logic [3:0] {
    IDLE, W_P0, W_P1, W_P2, W_P3, SETTLE, W_CTRL, WAIT, W_STOP, W_CLR, FIN
  } state_t;

  state_t               state;
  logic [2:0]           rr;
  logic [31:0]          period;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [31:0]          wdog;
  logic                 ok;
  logic                 wd;

  logic                 pick_vld;
  logic [2:0]           pick_id;
  logic [31:0]          pick_period;
  int                   idx;

  // Walk from the far end back toward rr so the first set bit at/after rr wins.
  always_comb begin
    pick_vld    = 1'b0;
    pick_id     = '0;
    pick_period = '0;
    idx         = 0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (req[idx]) begin
        pick_vld    = 1'b1;
        pick_id     = 3'(idx);
        pick_period = req_period[idx*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      rr             <= '0;
      period         <= '0;
      gnt_oh         <= '0;
      wdog           <= '0;
      ok             <= 1'b0;
      wd             <= 1'b0;
      done           <= '0;
      err            <= 1'b0;
      grant_id       <= '0;
      busy           <= 1'b0;
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
    end else begin
      done           <= '0;
      err            <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      case (state)
        IDLE: if (pick_vld) begin
          state          <= W_P0;
          grant_id       <= pick_id;
          gnt_oh         <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
          period         <= pick_period;
          busy           <= 1'b1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd2;
          tmr_writedata  <= pick_period[15:0];
        end
        W_P0: begin
          state          <= W_P1;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd3;
          tmr_writedata  <= period[31:16];
        end
        W_P1: begin
          state          <= W_P2;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd4;
          tmr_writedata  <= '0;
        end
        W_P2: begin
          state          <= W_P3;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd5;
          tmr_writedata  <= '0;
        end
        // Gap cycle lets the period-write force-reload stop finish before START.
        W_P3: state <= SETTLE;
        SETTLE: begin
          state          <= W_CTRL;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd1;
          tmr_writedata  <= 16'h0005;
        end
        W_CTRL: begin
          state <= WAIT;
          wdog  <= '0;
          ok    <= 1'b0;
          wd    <= 1'b0;
        end
        WAIT: begin
          if (!(|(req & gnt_oh))) begin
            state          <= W_STOP;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 4'd1;
            tmr_writedata  <= 16'h0008;
          end else if (tmr_irq) begin
            state          <= W_CLR;
            ok             <= 1'b1;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 4'd0;
            tmr_writedata  <= '0;
          end else if (wdog == WDOG_CYCLES - 32'd1) begin
            state          <= W_STOP;
            wd             <= 1'b1;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            tmr_address    <= 4'd1;
            tmr_writedata  <= 16'h0008;
          end else begin
            wdog <= wdog + 32'd1;
          end
        end
        W_STOP: begin
          state          <= W_CLR;
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 4'd0;
          tmr_writedata  <= '0;
        end
        W_CLR: begin
          state <= FIN;
          done  <= ok ? gnt_oh : '0;
          err   <= wd;
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          rr    <= (grant_id == 3'(NUM_REQ-1)) ? 3'd0 : grant_id + 3'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
